// File: rtl/weight_filter_pkg.sv
// Shared types and helpers for the weight tile boundary filter.
package weight_filter_pkg;

    // Per-tile handling of out-of-range elements.
    typedef enum logic {
        MODE_ZERO = 1'b0,
        MODE_DROP = 1'b1
    } filter_mode_e;

    // Width used for the bound comparison. One bit wider than the widest
    // supported coordinate (32 bits), so base + index can never wrap.
    localparam int LEGAL_W = 33;

    // Number of elements in one K x K x Tm x Tn tile.
    function automatic int unsigned tile_elems(input int unsigned k,
                                               input int unsigned tm,
                                               input int unsigned tn);
        return k * k * tm * tn;
    endfunction

    // An element is legal when both channel coordinates fall inside the layer.
    // Callers zero-extend their CW-bit values; the sums are formed one bit
    // wider than the operands, so a base near the top of its range cannot
    // wrap back into legality.
    function automatic logic elem_legal(input logic [31:0] baseM,
                                        input logic [31:0] tmIdx,
                                        input logic [31:0] baseN,
                                        input logic [31:0] tnIdx,
                                        input logic [31:0] boundM,
                                        input logic [31:0] boundN);
        logic [LEGAL_W-1:0] sumM;
        logic [LEGAL_W-1:0] sumN;
        sumM = {1'b0, baseM} + {1'b0, tmIdx};
        sumN = {1'b0, baseN} + {1'b0, tnIdx};
        return (sumM < {1'b0, boundM}) && (sumN < {1'b0, boundN});
    endfunction

endpackage

// File: rtl/weight_tile_counter.sv
// Four-level nested loop counter walking j, i, tm, tn (j fastest).
import weight_filter_pkg::*;

module weight_tile_counter #(
    parameter int K  = 3,
    parameter int Tm = 16,
    parameter int Tn = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_j,
    output logic [CW-1:0] o_i,
    output logic [CW-1:0] o_tm,
    output logic [CW-1:0] o_tn,
    output logic          o_last
);

    localparam logic [CW-1:0] J_MAX  = CW'(K - 1);
    localparam logic [CW-1:0] TM_MAX = CW'(Tm - 1);
    localparam logic [CW-1:0] TN_MAX = CW'(Tn - 1);

    logic [CW-1:0] r_j;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_tm;
    logic [CW-1:0] r_tn;

    logic w_jMax;
    logic w_iMax;
    logic w_tmMax;
    logic w_tnMax;

    assign w_jMax  = (r_j  == J_MAX);
    assign w_iMax  = (r_i  == J_MAX);
    assign w_tmMax = (r_tm == TM_MAX);
    assign w_tnMax = (r_tn == TN_MAX);

    // Advance the loop nest by one element per enable, wrapping each level
    // into the next; the last element of a tile wraps everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j  <= '0;
            r_i  <= '0;
            r_tm <= '0;
            r_tn <= '0;
        end else if (i_en) begin
            if (w_jMax) begin
                r_j <= '0;
                if (w_iMax) begin
                    r_i <= '0;
                    if (w_tmMax) begin
                        r_tm <= '0;
                        if (w_tnMax) begin
                            r_tn <= '0;
                        end else begin
                            r_tn <= r_tn + CW'(1);
                        end
                    end else begin
                        r_tm <= r_tm + CW'(1);
                    end
                end else begin
                    r_i <= r_i + CW'(1);
                end
            end else begin
                r_j <= r_j + CW'(1);
            end
        end
    end

    assign o_j    = r_j;
    assign o_i    = r_i;
    assign o_tm   = r_tm;
    assign o_tn   = r_tn;
    assign o_last = w_jMax && w_iMax && w_tmMax && w_tnMax;

endmodule

// File: rtl/weight_tile_filter.sv
// Streaming boundary filter for weight tiles: zero-fills or drops elements
// whose channel coordinates fall outside the layer, with valid/ready flow.
import weight_filter_pkg::*;

module weight_tile_filter #(
    parameter int DW = 32,
    parameter int CW = 16,
    parameter int M  = 32,
    parameter int N  = 32,
    parameter int Tm = 16,
    parameter int Tn = 16,
    parameter int K  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic [CW-1:0] tile_base_m,
    input  logic [CW-1:0] tile_base_n,
    input  logic          drop_mode,
    output logic          tile_done
);

    logic [CW-1:0] w_j;
    logic [CW-1:0] w_i;
    logic [CW-1:0] w_tm;
    logic [CW-1:0] w_tn;
    logic          w_last;

    logic [CW-1:0] r_baseM;
    logic [CW-1:0] r_baseN;
    filter_mode_e  r_mode;

    logic          r_outValid;
    logic [DW-1:0] r_outData;
    logic          r_tileDone;

    logic          w_accept;
    logic          w_first;
    logic [CW-1:0] w_baseM;
    logic [CW-1:0] w_baseN;
    filter_mode_e  w_mode;
    logic          w_legal;
    logic          w_emit;

    weight_tile_counter #(
        .K  (K),
        .Tm (Tm),
        .Tn (Tn),
        .CW (CW)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst),
        .i_en   (w_accept),
        .o_j    (w_j),
        .o_i    (w_i),
        .o_tm   (w_tm),
        .o_tn   (w_tn),
        .o_last (w_last)
    );

    // The output stage can take a new element whenever it is empty or
    // being drained this cycle.
    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Element 0 of a tile uses the live tile inputs (they are being captured
    // on this very accept); every later element uses the held copies.
    assign w_first = (w_j == '0) && (w_i == '0) && (w_tm == '0) && (w_tn == '0);
    assign w_baseM = w_first ? tile_base_m : r_baseM;
    assign w_baseN = w_first ? tile_base_n : r_baseN;
    assign w_mode  = w_first ? filter_mode_e'(drop_mode) : r_mode;

    assign w_legal = elem_legal(32'(w_baseM), 32'(w_tm),
                                32'(w_baseN), 32'(w_tn),
                                32'(M), 32'(N));

    // Zero-fill mode emits everything; drop mode emits only legal elements.
    assign w_emit = (w_mode == MODE_ZERO) || w_legal;

    // Hold the tile bases and mode from the first accept for the whole tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baseM <= '0;
            r_baseN <= '0;
            r_mode  <= MODE_ZERO;
        end else if (w_accept && w_first) begin
            r_baseM <= tile_base_m;
            r_baseN <= tile_base_n;
            r_mode  <= filter_mode_e'(drop_mode);
        end
    end

    // Output register: reload on an emitted accept, empty on a drop or a
    // drain, otherwise hold while the FIFO stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_accept) begin
            if (w_emit) begin
                r_outValid <= 1'b1;
                r_outData  <= w_legal ? in_data : '0;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Pulse once in the cycle after the final element of a tile is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tileDone <= 1'b0;
        end else begin
            r_tileDone <= w_accept && w_last;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign tile_done = r_tileDone;

endmodule

// File: doc/weight_tile_filter.md
# weight_tile_filter

Streaming boundary filter for weight tiles between the weight DMA read path and the weight FIFO. It is the next generation of the in-line weight filter. It walks the K×K×Tm×Tn tile loop nest and checks each element against the layer bounds M/N. Out-of-range elements are either replaced with zero or dropped from the stream, selected per tile. Unlike the previous filter, it carries a full valid/ready handshake with backpressure and reports tile completion.

## Interface
Parameters:
- DW, 32, data element width
- CW, 16, counter / coordinate width
- M, 32, output-channel bound of the layer
- N, 32, input-channel bound of the layer
- Tm, 16, output-channel tile size
- Tn, 16, input-channel tile size
- K, 3, kernel size (loop runs K×K)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  upstream element valid
- in_ready  out  1  filter can accept
- in_data  in  DW  weight element
- out_valid  out  1  element available to FIFO
- out_ready  in  1  FIFO can accept
- out_data  out  DW  filtered element
- tile_base_m  in  CW  output-channel base of current tile
- tile_base_n  in  CW  input-channel base of current tile
- drop_mode  in  1  0 = zero-fill illegal elements, 1 = drop them
- tile_done  out  1  one-cycle pulse, tile fully consumed

## Operation
- Accept = in_valid && in_ready.
- Loop nest order, fastest first: j (0..K-1), i (0..K-1), tm (0..Tm-1), tn (0..Tn-1). Each accept advances the nest by one. TILE_ELEMS = K·K·Tm·Tn.
- tile_base_m, tile_base_n and drop_mode are captured on the first accept of a tile, when all counters are 0. They are held for the whole tile. Changes mid-tile are ignored.
- An element is legal when (base_m + tm < M) && (base_n + tn < N).
  - Sums are computed at CW+1 bits, so a base near 2^CW never wraps into legality.
- Zero-fill mode: every accepted element is emitted. Illegal elements are emitted as 0.
- Drop mode: legal elements are emitted unchanged. Illegal elements are consumed and never emitted.
- On the accept of element TILE_ELEMS-1, the counters wrap to 0 and tile_done pulses in the next cycle.
- Back-to-back tiles are supported with no bubble.

## Timing
- Reset values: out_valid=0, out_data=0, tile_done=0, all counters 0, captured bases and mode 0.
- in_ready = !out_valid || out_ready, a combinational output. It is 1 while in reset.
- Latency: 1 cycle from accept to out_valid/out_data.
  - Output register update when loaded: out_data ← in_data (or 0 if illegal in zero-fill mode); out_valid ← 1.
- Output register with no accept: out_valid ← 0 when out_ready=1. Otherwise out_valid and out_data hold stable.
- Dropped element with out_ready=1: out_valid ← 0, and out_data holds its last value.
- Simultaneous output drain and input accept in the same cycle: the register reloads with no bubble. Sustained rate is 1 element/cycle.
- tile_done is asserted for exactly 1 cycle, one cycle after the last accept, regardless of out_ready.
  - In zero-fill mode it coincides with the final element's out_valid.
- If rst is asserted mid-tile, all state clears immediately. The next accept is element 0 of a new tile and re-captures bases and mode.
- K, Tm and Tn must be ≥1. TILE_ELEMS must fit in CW bits per counter field.

## Structure
- Package weight_filter_pkg holds:
  - constants MODE_ZERO=0 and MODE_DROP=1;
  - function tile_elems(K, Tm, Tn);
  - the legality function, with explicit CW+1 widening.
- One sub-module, weight_tile_counter:
  - a 4-level nested counter with enable and active-low async reset;
  - outputs j, i, tm, tn and a last flag (all counters at max).
- The top holds the capture registers, the legality compare, the output register and the handshake.
- Estimated size is about 200 lines total.

## Test plan
Small configuration for all tests: K=3, Tm=2, Tn=2, M=3, N=3, giving TILE_ELEMS=36 with in_data=index+1.
- Base m=0, n=0, zero-fill, out_ready=1: 36 outputs equal to 1..36, in order. tile_done pulses once, 1 cycle after accept 35.
- Base m=2, n=2, zero-fill: outputs 1..9 unchanged, then elements 10..36 emitted as 0. 36 outputs total.
- Base m=2, n=2, drop mode: exactly 9 outputs (1..9). tile_done follows the 36th accept. in_ready stays 1 throughout.
- Base m=0, n=0, out_ready toggling 1010…: no element lost or duplicated, and out_data is stable while out_valid && !out_ready.
- Base m=0xFFFF, n=0, zero-fill: all 36 outputs are 0, with no wrap into legality.
- rst asserted after 20 accepts, then a new tile with base m=0, n=0: outputs restart at 1, bases re-captured, and exactly one tile_done after 36 more accepts.
